// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: FSM encoding, memory-select constants and default address step for mem_access_ctrl
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic MEM_SEL_IMEM = 1'b0;
  localparam logic MEM_SEL_DMEM = 1'b1;
  localparam int DEFAULT_ADDR_STEP = 4;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: host-side imem/dmem access FSM used while the CPU is parked; MEM_ACCESS_BURST_EN enables req_len read bursts
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_STEP = DEFAULT_ADDR_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_global_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        req_abort,
  output logic [31:0] cpu_ctrl_imem_addr,
  output logic [31:0] cpu_ctrl_imem_wdata,
  output logic        cpu_ctrl_imem_we,
  input  logic [31:0] cpu_ctrl_imem_rdata,
  output logic [31:0] cpu_ctrl_dmem_addr,
  output logic [31:0] cpu_ctrl_dmem_wdata,
  output logic        cpu_ctrl_dmem_we,
  input  logic [31:0] cpu_ctrl_dmem_rdata,
  output logic        busy
);
  state_t state, state_n;
  logic we_q, sel_q, accept, abort, hs, last_word, next_word;
  assign req_ready = state == IDLE && !cpu_global_en;
  assign busy = state != IDLE;
`ifdef MEM_ACCESS_BURST_EN
  logic [7:0] cnt;
  assign last_word = cnt == 8'd0;
  // writes are always single-word, so their count starts at zero
  always_ff @(posedge clk) begin
    if (rst) cnt <= 8'd0;
    else if (accept) cnt <= req_we ? 8'd0 : req_len;
    else if (next_word) cnt <= cnt - 8'd1;
  end
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign last_word = 1'b1;
`endif
  always_comb begin
    accept = req_valid && req_ready;
    abort = cpu_global_en && state != IDLE;
    hs = state == RESP && rsp_ready;
    state_n = abort ? IDLE :
              state == IDLE ? (accept ? ACCESS : IDLE) :
              state == ACCESS ? (we_q ? RESP : WAIT) :
              state == WAIT ? RESP :
              hs ? (last_word ? IDLE : ACCESS) : RESP;
    next_word = state == RESP && state_n == ACCESS;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      sel_q <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last <= 1'b0;
      req_abort <= 1'b0;
      cpu_ctrl_imem_addr <= '0;
      cpu_ctrl_imem_wdata <= '0;
      cpu_ctrl_imem_we <= 1'b0;
      cpu_ctrl_dmem_addr <= '0;
      cpu_ctrl_dmem_wdata <= '0;
      cpu_ctrl_dmem_we <= 1'b0;
    end else begin
      req_abort <= abort;
      rsp_valid <= state_n == RESP;
      rsp_last <= state_n == RESP && last_word;
      cpu_ctrl_imem_we <= accept && req_we && req_sel == MEM_SEL_IMEM;
      cpu_ctrl_dmem_we <= accept && req_we && req_sel == MEM_SEL_DMEM;
      if (accept) begin
        we_q <= req_we;
        sel_q <= req_sel;
      end
      if (accept && req_sel == MEM_SEL_IMEM) begin
        cpu_ctrl_imem_addr <= req_addr;
        cpu_ctrl_imem_wdata <= req_wdata;
      end
      if (accept && req_sel == MEM_SEL_DMEM) begin
        cpu_ctrl_dmem_addr <= req_addr;
        cpu_ctrl_dmem_wdata <= req_wdata;
      end
      if (next_word && sel_q == MEM_SEL_IMEM) cpu_ctrl_imem_addr <= cpu_ctrl_imem_addr + 32'(ADDR_STEP);
      if (next_word && sel_q == MEM_SEL_DMEM) cpu_ctrl_dmem_addr <= cpu_ctrl_dmem_addr + 32'(ADDR_STEP);
      if (state == WAIT && !abort) rsp_rdata <= sel_q == MEM_SEL_DMEM ? cpu_ctrl_dmem_rdata : cpu_ctrl_imem_rdata;
      if (state == ACCESS && we_q && !abort) rsp_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench for mem_access_ctrl against a transaction-level model
module tb_mem_access_ctrl;
  localparam int STEP = 4;
`ifdef MEM_ACCESS_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cpu_global_en = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_sel = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [7:0] req_len = '0;
  logic req_ready, rsp_valid, rsp_last, req_abort, busy, imem_we, dmem_we;
  logic [31:0] rsp_rdata, imem_addr, imem_wdata, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  int checks = 0, fails = 0;
  logic [31:0] got_rdata[$], got_addr[$];
  logic got_last[$];
  int got_lat[$];
  int imem_we_cnt, dmem_we_cnt, unstable, timeouts = 0;
  logic [31:0] we_addr, we_data;

  mem_access_ctrl #(.ADDR_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .cpu_global_en(cpu_global_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .req_abort(req_abort),
    .cpu_ctrl_imem_addr(imem_addr), .cpu_ctrl_imem_wdata(imem_wdata), .cpu_ctrl_imem_we(imem_we),
    .cpu_ctrl_imem_rdata(imem_rdata),
    .cpu_ctrl_dmem_addr(dmem_addr), .cpu_ctrl_dmem_wdata(dmem_wdata), .cpu_ctrl_dmem_we(dmem_we),
    .cpu_ctrl_dmem_rdata(dmem_rdata),
    .busy(busy)
  );

  function automatic logic [31:0] mem_f(input logic sel, input logic [31:0] a);
    if (!sel && a == 32'h40) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ (sel ? 32'h5A5A_0F0F : 32'h0BAD_F00D);
  endfunction
  assign imem_rdata = mem_f(1'b0, imem_addr);
  assign dmem_rdata = mem_f(1'b1, dmem_addr);

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
  endtask

  // drives one request and records every response, write pulse and latency seen until the block returns idle
  task automatic run_txn(input logic we, input logic sel, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] len, input int stall);
    int lat = 1, guard = 0, stalled = 0;
    logic [31:0] held = '0;
    got_rdata.delete(); got_addr.delete(); got_last.delete(); got_lat.delete();
    imem_we_cnt = 0; dmem_we_cnt = 0; unstable = 0;
    while (!req_ready && guard < 20) begin step; guard++; end
    if (!req_ready) timeouts++;
    guard = 0;
    req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata; req_len = len;
    step;
    req_valid = 1'b0; req_we = 1'($urandom); req_sel = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_len = 8'($urandom);
    while (guard < 300) begin
      if (imem_we) begin imem_we_cnt++; we_addr = imem_addr; we_data = imem_wdata; end
      if (dmem_we) begin dmem_we_cnt++; we_addr = dmem_addr; we_data = dmem_wdata; end
      if (rsp_valid && stalled == 0) begin
        got_rdata.push_back(rsp_rdata); got_last.push_back(rsp_last); got_lat.push_back(lat);
        got_addr.push_back(sel ? dmem_addr : imem_addr);
        held = rsp_rdata;
      end else if (rsp_valid && rsp_rdata !== held) unstable++;
      if (rsp_valid && stalled >= stall) begin
        rsp_ready = 1'b1; step; rsp_ready = 1'b0; lat = 1; stalled = 0;
        if (!busy) break;
      end else if (rsp_valid) begin
        stalled++; step;
      end else if (!busy) break;
      else begin step; lat++; end
      guard++;
    end
    if (guard >= 300) timeouts++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    checks++; if ({rsp_valid, rsp_last, req_abort, imem_we, dmem_we, busy} !== 6'b0) begin fails++; $display("FAIL reset_flags got=%b exp=000000", {rsp_valid, rsp_last, req_abort, imem_we, dmem_we, busy}); end
    checks++; if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata} !== 128'h0) begin fails++; $display("FAIL reset_addr_data got=%h %h %h %h exp=0", imem_addr, imem_wdata, dmem_addr, dmem_wdata); end
    checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_single_write;
    run_txn(1'b1, 1'b1, 32'h1C, 32'hDEAD_BEEF, 8'd0, 0);
    checks++; if (dmem_we_cnt !== 1 || imem_we_cnt !== 0) begin fails++; $display("FAIL write_we_cycles got=d%0d i%0d exp=d1 i0", dmem_we_cnt, imem_we_cnt); end
    checks++; if ({we_addr, we_data} !== {32'h1C, 32'hDEAD_BEEF}) begin fails++; $display("FAIL write_addr_data got=%h %h exp=0000001c deadbeef", we_addr, we_data); end
    checks++; if (got_rdata.size() !== 1) begin fails++; $display("FAIL write_rsp_count got=%0d exp=1", got_rdata.size()); end
    checks++; if ({got_last[0], got_rdata[0]} !== {1'b1, 32'h0}) begin fails++; $display("FAIL write_rsp got=last%b %h exp=last1 0", got_last[0], got_rdata[0]); end
    checks++; if (got_lat[0] !== 2) begin fails++; $display("FAIL write_latency got=%0d exp=2", got_lat[0]); end
    run_txn(1'b1, 1'b0, 32'h80, 32'hCAFE_F00D, 8'd5, 0);
    checks++; if (imem_we_cnt !== 1 || dmem_we_cnt !== 0 || got_rdata.size() !== 1) begin fails++; $display("FAIL write_len_ignored got=i%0d d%0d rsp%0d exp=i1 d0 rsp1", imem_we_cnt, dmem_we_cnt, got_rdata.size()); end
    checks++; if (got_last[0] !== 1'b1) begin fails++; $display("FAIL write_len_last got=%b exp=1", got_last[0]); end
  endtask

  task automatic test_single_read;
    run_txn(1'b0, 1'b0, 32'h40, 32'h0, 8'd0, 0);
    checks++; if (got_rdata.size() !== 1) begin fails++; $display("FAIL read_rsp_count got=%0d exp=1", got_rdata.size()); end
    checks++; if (got_rdata[0] !== 32'h1234_5678) begin fails++; $display("FAIL read_rdata got=%h exp=12345678", got_rdata[0]); end
    checks++; if (got_lat[0] !== 3) begin fails++; $display("FAIL read_latency got=%0d exp=3", got_lat[0]); end
    checks++; if (got_last[0] !== 1'b1 || imem_we_cnt + dmem_we_cnt !== 0) begin fails++; $display("FAIL read_last_we got=last%b we%0d exp=last1 we0", got_last[0], imem_we_cnt + dmem_we_cnt); end
  endtask

  task automatic test_burst;
    int n;
    n = BURST ? 4 : 1;
    run_txn(1'b0, 1'b1, 32'h100, 32'h0, 8'd3, 1);
    checks++; if (got_rdata.size() !== n) begin fails++; $display("FAIL burst_count got=%0d exp=%0d", got_rdata.size(), n); end
    for (int k = 0; k < n && k < got_rdata.size(); k++) begin
      logic [31:0] ea;
      ea = 32'h100 + 32'(k * STEP);
      checks++; if (got_addr[k] !== ea) begin fails++; $display("FAIL burst_addr[%0d] got=%h exp=%h", k, got_addr[k], ea); end
      checks++; if (got_rdata[k] !== mem_f(1'b1, ea)) begin fails++; $display("FAIL burst_rdata[%0d] got=%h exp=%h", k, got_rdata[k], mem_f(1'b1, ea)); end
      checks++; if (got_last[k] !== (k == n - 1)) begin fails++; $display("FAIL burst_last[%0d] got=%b exp=%b", k, got_last[k], k == n - 1); end
      checks++; if (got_lat[k] !== 3) begin fails++; $display("FAIL burst_latency[%0d] got=%0d exp=3", k, got_lat[k]); end
    end
  endtask

  task automatic test_backpressure_wrap;
    int n;
    logic [31:0] ea;
    n = BURST ? 2 : 1;
    ea = 32'hFFFF_FFFC + 32'((n - 1) * STEP);
    run_txn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 8'd1, 5);
    checks++; if (unstable !== 0) begin fails++; $display("FAIL stall_rdata_stable got=%0d changes exp=0", unstable); end
    checks++; if (got_rdata.size() !== n) begin fails++; $display("FAIL wrap_count got=%0d exp=%0d", got_rdata.size(), n); end
    checks++; if (got_addr[n-1] !== ea) begin fails++; $display("FAIL wrap_addr got=%h exp=%h", got_addr[n-1], ea); end
    checks++; if (got_rdata[n-1] !== mem_f(1'b0, ea)) begin fails++; $display("FAIL wrap_rdata got=%h exp=%h", got_rdata[n-1], mem_f(1'b0, ea)); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      logic we, sel;
      logic [31:0] addr, wdata;
      logic [7:0] len;
      int stall, n;
      we = $urandom_range(0, 3) == 0;
      sel = 1'($urandom);
      addr = $urandom & 32'hFFFF_FFFC;
      wdata = $urandom;
      len = 8'($urandom_range(0, 3));
      stall = $urandom_range(0, 3);
      n = (we || !BURST) ? 1 : int'(len) + 1;
      run_txn(we, sel, addr, wdata, len, stall);
      checks++; if (got_rdata.size() !== n) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", i, got_rdata.size(), n); end
      for (int k = 0; k < n && k < got_rdata.size(); k++) begin
        logic [31:0] ea;
        ea = addr + 32'(k * STEP);
        checks++; if (got_addr[k] !== ea) begin fails++; $display("FAIL rand%0d_addr[%0d] got=%h exp=%h", i, k, got_addr[k], ea); end
        checks++; if (got_rdata[k] !== (we ? 32'h0 : mem_f(sel, ea))) begin fails++; $display("FAIL rand%0d_rdata[%0d] got=%h exp=%h", i, k, got_rdata[k], we ? 32'h0 : mem_f(sel, ea)); end
        checks++; if (got_last[k] !== (k == n - 1)) begin fails++; $display("FAIL rand%0d_last[%0d] got=%b exp=%b", i, k, got_last[k], k == n - 1); end
        checks++; if (got_lat[k] !== (we ? 2 : 3)) begin fails++; $display("FAIL rand%0d_latency[%0d] got=%0d exp=%0d", i, k, got_lat[k], we ? 2 : 3); end
      end
      checks++; if ((sel ? dmem_we_cnt : imem_we_cnt) !== int'(we) || (sel ? imem_we_cnt : dmem_we_cnt) !== 0) begin fails++; $display("FAIL rand%0d_we got=i%0d d%0d exp=sel%b we%b", i, imem_we_cnt, dmem_we_cnt, sel, we); end
      if (we) begin
        checks++; if ({we_addr, we_data} !== {addr, wdata}) begin fails++; $display("FAIL rand%0d_write got=%h %h exp=%h %h", i, we_addr, we_data, addr, wdata); end
      end
    end
    checks++; if (timeouts !== 0) begin fails++; $display("FAIL txn_timeouts got=%0d exp=0", timeouts); end
  endtask

  task automatic test_abort;
    int ab = 0, rv = 0, rr = 0, wc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 1'b1; req_addr = 32'h200; req_len = 8'd0;
    step;
    req_valid = 1'b0;
    step;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL abort_setup got=busy%b valid%b exp=busy1 valid0", busy, rsp_valid); end
    cpu_global_en = 1'b1;
    step;
    checks++; if ({req_abort, rsp_valid, busy, req_ready} !== 4'b1000) begin fails++; $display("FAIL abort_next got=%b exp=1000", {req_abort, rsp_valid, busy, req_ready}); end
    repeat (5) begin
      step;
      ab += int'(req_abort); rv += int'(rsp_valid); rr += int'(req_ready);
    end
    checks++; if ({ab, rv, rr} !== {32'd0, 32'd0, 32'd0}) begin fails++; $display("FAIL abort_hold got=abort%0d valid%0d ready%0d exp=0 0 0", ab, rv, rr); end
    cpu_global_en = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_release got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_we = 1'b1; req_sel = 1'b0; req_addr = 32'h300; req_wdata = 32'h1111_2222;
    step;
    req_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin fails++; $display("FAIL abort_write_issue got=%b exp=1", imem_we); end
    cpu_global_en = 1'b1;
    step;
    checks++; if ({imem_we, req_abort, rsp_valid} !== 3'b010) begin fails++; $display("FAIL abort_write got=%b exp=010", {imem_we, req_abort, rsp_valid}); end
    repeat (3) begin step; wc += int'(imem_we) + int'(dmem_we) + int'(rsp_valid); end
    checks++; if (wc !== 0) begin fails++; $display("FAIL abort_write_quiet got=%0d exp=0", wc); end
    cpu_global_en = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_burst;
    int guard = 0;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 1'b1; req_addr = 32'h300; req_len = 8'd3;
    step;
    req_valid = 1'b0;
    while (!rsp_valid && guard < 10) begin step; guard++; end
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rst_burst_reach_resp got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    step;
    checks++; if ({rsp_valid, rsp_last, req_abort, imem_we, dmem_we, busy} !== 6'b0) begin fails++; $display("FAIL rst_burst_flags got=%b exp=000000", {rsp_valid, rsp_last, req_abort, imem_we, dmem_we, busy}); end
    checks++; if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata, rsp_rdata} !== 160'h0) begin fails++; $display("FAIL rst_burst_data got=%h %h %h %h %h exp=0", imem_addr, imem_wdata, dmem_addr, dmem_wdata, rsp_rdata); end
    rst = 1'b0;
    step;
    run_txn(1'b0, 1'b0, 32'h40, 32'h0, 8'd0, 0);
    checks++; if (got_rdata.size() !== 1 || got_rdata[0] !== 32'h1234_5678) begin fails++; $display("FAIL rst_burst_new_req got=n%0d %h exp=n1 12345678", got_rdata.size(), got_rdata[0]); end
    checks++; if (got_lat[0] !== 3) begin fails++; $display("FAIL rst_burst_new_latency got=%0d exp=3", got_lat[0]); end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_burst;
    test_backpressure_wrap;
    test_random;
    test_abort;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
